script_player: RTL and testbench
================================

Name: script_player

Overview:
- Clocked, parametrised successor to the scripted tic-tac-toe player.
- Replays one of NUM_GAMES move scripts onto the shared board bus, selected at runtime.
- Adds a submit/accept handshake with the board, skip-on-reject, a response timeout, and new-game reset sequencing.
- Drives the board through tri-state outputs, shared with the AI.

Parameters:
- NUM_CELLS, 9, board cells; script value NUM_CELLS is the end-of-script marker.
- INDEX_W, 4, width of update_loc; must satisfy 2^INDEX_W > NUM_CELLS.
- MAX_MOVES, 8, script entries per game; also caps the step counter.
- NUM_GAMES, 4, number of scripts; GSEL_W = clog2(NUM_GAMES).
- RESET_CYCLES, 2, cycles the board reset output is held high on a new game.
- RESP_TIMEOUT, 16, cycles to wait for ack/nak before treating the move as rejected.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- turn  in  1  current turn; TURN_PLAYER (0) = player, 1 = AI.
- game_sel  in  GSEL_W  script select; sampled only at reset release and at new-game entry.
- new_game  in  1  one-cycle request to restart the game.
- move_ack  in  1  board accepted the last submit.
- move_nak  in  1  board rejected the last submit (cell occupied or illegal).
- update_loc  out(tri)  INDEX_W  cell to play.
- submit  out(tri)  1  one-cycle move strobe.
- reset  out(tri)  1  board reset request.
- move_count  out  4  accepted player moves in this game.
- script_done  out  1  script exhausted; no further submits until a new game.
- busy  out  1  high in ISSUE, WAIT_RESP, RESET_GAME.

Behaviour:
- Tri-state rule: update_loc, submit and reset are 'bz whenever turn != TURN_PLAYER. Otherwise they are driven from registers: submit and reset are 0 outside their active states, and update_loc holds the last issued index (0 after reset).
- While rst_n=0 at a clock edge, all of the following are loaded:
  - state=WAIT_TURN, step=0, move_count=0, script_done=0, busy=0.
  - Internal submit=0, reset=0, timer=0, pend_new=0.
  - turn_q=1 (so a player turn present at reset release counts as a turn start).
  - gsel_r=game_sel; an out-of-range value maps to game 0.
- turn_start = (turn==TURN_PLAYER) && (turn_q!=TURN_PLAYER); turn_q registers turn every cycle.
- States:
  - WAIT_TURN:
    - On turn_start, if entry(gsel_r, step) == NUM_CELLS or step==MAX_MOVES: set script_done=1 and go to DONE.
    - Otherwise go to ISSUE.
  - ISSUE (1 cycle): update_loc = entry, submit=1, timer=0; go to WAIT_RESP. Submit is exactly one cycle wide.
  - WAIT_RESP:
    - move_ack: step++, move_count++, go to WAIT_TURN.
    - move_nak, or timer reaching RESP_TIMEOUT-1: step++ with no move_count change; if the next entry is valid, go to ISSUE next cycle, else script_done=1 and go to DONE.
    - ack and nak in the same cycle: ack wins.
    - The first ack/nak is accepted in the cycle after ISSUE at the earliest.
  - DONE: hold everything; only new_game leaves this state.
  - RESET_GAME: reset=1 for exactly RESET_CYCLES cycles, then go to WAIT_TURN.
    - On entry: step=0, move_count=0, script_done=0, gsel_r re-sampled from game_sel.
    - turn_q is forced to 1 on exit so the current player turn re-triggers.
- Turn loss: if turn goes to AI while in ISSUE or WAIT_RESP, abort to WAIT_TURN with no step advance; the same entry is retried on the next turn.
- new_game handling:
  - new_game sets pend_new in any state.
  - When pend_new=1 and turn==TURN_PLAYER, the next state is RESET_GAME (clearing pend_new). This overrides every other transition except rst_n.
  - new_game pulses during RESET_GAME are absorbed: the sequence is not restarted or extended.
- Counters:
  - step saturates at MAX_MOVES.
  - move_count is 4 bits and saturates at 15.
  - timer is clog2(RESP_TIMEOUT) bits and is cleared in ISSUE.

Decomposition:
- Shared package/defines: TURN_PLAYER, TURN_AI, NUM_CELLS, END_MARK (=NUM_CELLS), INDEX_W, state encoding (WAIT_TURN, ISSUE, WAIT_RESP, DONE, RESET_GAME).
- One sub-module, script_player_rom: combinational (game, step) -> INDEX_W entry. It holds the four scripts, padded with END_MARK:
  - Game 0: 4,3,6,8,1
  - Game 1: 4,3,1,8,6
  - Game 2: 2,0,7,8
  - Game 3: 8,7,2,3,1

Test Plan:
- Reset-time selection: game_sel=0 at rst_n release with turn=0 -> submit pulses one cycle after release with update_loc=4; ack -> move_count=1. Repeat over alternating turns -> submitted sequence is 4,3,6,8,1, then on the next player turn script_done=1 and no submit.
- Skip on reject: game_sel=2, nak the first submit -> the next cycle path issues update_loc=0 with no turn change; move_count stays 0.
- Timeout: game_sel=1, no ack/nak -> after 16 WAIT_RESP cycles the next entry (3) is submitted; ack and nak together -> treated as ack.
- Turn loss: turn flips to 1 in WAIT_RESP -> update_loc, submit and reset read 'bz; turn back to 0 -> the same cell is resubmitted.
- New game mid-game: pulse new_game mid-game with game_sel=3 -> reset high exactly 2 cycles, move_count=0, first submit is update_loc=8. A second new_game during RESET_GAME -> reset still 2 cycles total.
- Reset mid-operation: rst_n low during WAIT_RESP -> next cycle submit=0, step=0, script_done=0.

Source files
------------

// File: rtl/script_player_pkg.sv
// Shared constants, turn encoding and FSM state type for the scripted tic-tac-toe player.
package script_player_pkg;

  localparam logic TURN_PLAYER  = 1'b0;
  localparam logic TURN_AI      = 1'b1;

  localparam int NUM_CELLS    = 9;
  localparam int END_MARK     = NUM_CELLS;
  localparam int INDEX_W      = 4;
  localparam int MAX_MOVES    = 8;
  localparam int NUM_GAMES    = 4;
  localparam int RESET_CYCLES = 2;
  localparam int RESP_TIMEOUT = 16;

  typedef enum logic [2:0] {
    WAIT_TURN,
    ISSUE,
    WAIT_RESP,
    DONE,
    RESET_GAME
  } state_t;

endpackage

// File: rtl/script_player_if.sv
// Control/handshake bundle between the board and the scripted player.
interface script_player_if
  import script_player_pkg::*;
#(
  parameter int SEL_W = $clog2(NUM_GAMES)
);

  logic             turn;
  logic [SEL_W-1:0] game_sel;
  logic             new_game;
  logic             move_ack;
  logic             move_nak;
  logic [3:0]       move_count;
  logic             script_done;
  logic             busy;

  modport master (
    input  turn, game_sel, new_game, move_ack, move_nak,
    output move_count, script_done, busy
  );

  modport slave (
    output turn, game_sel, new_game, move_ack, move_nak,
    input  move_count, script_done, busy
  );

endinterface

// File: rtl/script_player_rom.sv
// Combinational move-script table: (game, step) -> board cell, END_VAL past the script end.
module script_player_rom
  import script_player_pkg::*;
#(
  parameter int ENTRY_W = INDEX_W,
  parameter int GSEL_W  = 2,
  parameter int STEP_W  = 4,
  parameter int END_VAL = END_MARK
) (
  input  logic [GSEL_W-1:0]  game,
  input  logic [STEP_W-1:0]  step,
  output logic [ENTRY_W-1:0] entry
);

  localparam int ROM_GAMES = 4;
  localparam int ROM_DEPTH = 8;

  localparam int SCRIPTS [ROM_GAMES][ROM_DEPTH] = '{
    '{4, 3, 6, 8, 1, END_VAL, END_VAL, END_VAL},
    '{4, 3, 1, 8, 6, END_VAL, END_VAL, END_VAL},
    '{2, 0, 7, 8, END_VAL, END_VAL, END_VAL, END_VAL},
    '{8, 7, 2, 3, 1, END_VAL, END_VAL, END_VAL}
  };

  // Anything outside the table reads as the end-of-script marker.
  always_comb begin
    entry = ENTRY_W'(END_VAL);
    for (int g = 0; g < ROM_GAMES; g++) begin
      for (int s = 0; s < ROM_DEPTH; s++) begin
        if (int'(game) == g && int'(step) == s) begin
          entry = ENTRY_W'(SCRIPTS[g][s]);
        end
      end
    end
  end

endmodule

// File: rtl/script_player.sv
// Scripted player: replays a selected move script onto the shared tri-state board bus
// with submit/ack handshake, skip-on-reject, response timeout and new-game sequencing.
module script_player
  import script_player_pkg::*;
#(
  parameter int NUM_CELLS    = script_player_pkg::NUM_CELLS,
  parameter int INDEX_W      = script_player_pkg::INDEX_W,
  parameter int MAX_MOVES    = script_player_pkg::MAX_MOVES,
  parameter int NUM_GAMES    = script_player_pkg::NUM_GAMES,
  parameter int RESET_CYCLES = script_player_pkg::RESET_CYCLES,
  parameter int RESP_TIMEOUT = script_player_pkg::RESP_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  script_player_if.master    bus,
  output wire [INDEX_W-1:0]  update_loc,
  output wire                submit,
  output wire                reset
);

  localparam int GSEL_W  = (NUM_GAMES > 1) ? $clog2(NUM_GAMES) : 1;
  localparam int STEP_W  = $clog2(MAX_MOVES + 1);
  localparam int TIMER_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam int RCNT_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  state_t             state, state_nxt;
  logic [STEP_W-1:0]  step, step_nxt, step_inc;
  logic [3:0]         move_count, move_count_nxt;
  logic               script_done, script_done_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [RCNT_W-1:0]  rcnt, rcnt_nxt;
  logic               pend_new, pend_new_nxt;
  logic               turn_q, turn_q_nxt;
  logic [GSEL_W-1:0]  gsel_r, gsel_nxt, gsel_in;
  logic [INDEX_W-1:0] loc_r, loc_nxt, cur_entry, next_entry;
  logic               submit_r, reset_r;
  logic               player_turn, turn_start, cur_end, next_end;

  assign player_turn = (bus.turn == TURN_PLAYER);
  assign turn_start  = player_turn && (turn_q != TURN_PLAYER);
  assign gsel_in     = (int'(bus.game_sel) < NUM_GAMES) ? GSEL_W'(bus.game_sel) : '0;
  assign step_inc    = (step >= STEP_W'(MAX_MOVES)) ? step : step + STEP_W'(1);

  // Two lookups: the entry at the current step, and the one a skip would move to.
  script_player_rom #(
    .ENTRY_W (INDEX_W),
    .GSEL_W  (GSEL_W),
    .STEP_W  (STEP_W),
    .END_VAL (NUM_CELLS)
  ) u_rom_cur (
    .game  (gsel_r),
    .step  (step),
    .entry (cur_entry)
  );

  script_player_rom #(
    .ENTRY_W (INDEX_W),
    .GSEL_W  (GSEL_W),
    .STEP_W  (STEP_W),
    .END_VAL (NUM_CELLS)
  ) u_rom_nxt (
    .game  (gsel_r),
    .step  (step_inc),
    .entry (next_entry)
  );

  assign cur_end  = (cur_entry == INDEX_W'(NUM_CELLS)) || (step >= STEP_W'(MAX_MOVES));
  assign next_end = (next_entry == INDEX_W'(NUM_CELLS)) || (step_inc >= STEP_W'(MAX_MOVES));

  always_comb begin
    state_nxt       = state;
    step_nxt        = step;
    move_count_nxt  = move_count;
    script_done_nxt = script_done;
    timer_nxt       = timer;
    rcnt_nxt        = rcnt;
    gsel_nxt        = gsel_r;
    loc_nxt         = loc_r;
    turn_q_nxt      = bus.turn;
    pend_new_nxt    = pend_new | (bus.new_game && (state != RESET_GAME));

    unique case (state)
      WAIT_TURN: begin
        if (turn_start) begin
          if (cur_end) begin
            script_done_nxt = 1'b1;
            state_nxt       = DONE;
          end else begin
            loc_nxt   = cur_entry;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        timer_nxt = '0;
        state_nxt = player_turn ? WAIT_RESP : WAIT_TURN;
      end
      WAIT_RESP: begin
        if (!player_turn) begin
          state_nxt = WAIT_TURN;
        end else if (bus.move_ack) begin
          step_nxt       = step_inc;
          move_count_nxt = (move_count == 4'd15) ? move_count : move_count + 4'd1;
          state_nxt      = WAIT_TURN;
        end else if (bus.move_nak || (timer == TIMER_W'(RESP_TIMEOUT - 1))) begin
          step_nxt = step_inc;
          if (next_end) begin
            script_done_nxt = 1'b1;
            state_nxt       = DONE;
          end else begin
            loc_nxt   = next_entry;
            state_nxt = ISSUE;
          end
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end
      DONE: begin
        state_nxt = DONE;
      end
      RESET_GAME: begin
        if (rcnt == RCNT_W'(RESET_CYCLES - 1)) begin
          turn_q_nxt = TURN_AI;
          state_nxt  = WAIT_TURN;
        end else begin
          rcnt_nxt = rcnt + RCNT_W'(1);
        end
      end
      default: state_nxt = WAIT_TURN;
    endcase

    // A pending restart pre-empts whatever the script was doing once the player holds the turn.
    if (pend_new && player_turn && (state != RESET_GAME)) begin
      state_nxt       = RESET_GAME;
      pend_new_nxt    = 1'b0;
      step_nxt        = '0;
      move_count_nxt  = '0;
      script_done_nxt = 1'b0;
      gsel_nxt        = gsel_in;
      rcnt_nxt        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= WAIT_TURN;
      step        <= '0;
      move_count  <= '0;
      script_done <= 1'b0;
      timer       <= '0;
      rcnt        <= '0;
      pend_new    <= 1'b0;
      turn_q      <= TURN_AI;
      gsel_r      <= gsel_in;
      loc_r       <= '0;
      submit_r    <= 1'b0;
      reset_r     <= 1'b0;
    end else begin
      state       <= state_nxt;
      step        <= step_nxt;
      move_count  <= move_count_nxt;
      script_done <= script_done_nxt;
      timer       <= timer_nxt;
      rcnt        <= rcnt_nxt;
      pend_new    <= pend_new_nxt;
      turn_q      <= turn_q_nxt;
      gsel_r      <= gsel_nxt;
      loc_r       <= loc_nxt;
      submit_r    <= (state_nxt == ISSUE);
      reset_r     <= (state_nxt == RESET_GAME);
    end
  end

  assign bus.move_count  = move_count;
  assign bus.script_done = script_done;
  assign bus.busy        = (state == ISSUE) || (state == WAIT_RESP) || (state == RESET_GAME);

  // The board bus is shared with the AI: release it whenever it is not our turn.
  assign update_loc = player_turn ? loc_r    : {INDEX_W{1'bz}};
  assign submit     = player_turn ? submit_r : 1'bz;
  assign reset      = player_turn ? reset_r  : 1'bz;

endmodule

// File: tb/tb_script_player.sv
// Directed bench for script_player: script replay, skip, timeout, turn loss, new game, reset.
module tb_script_player;

  logic clk = 1'b0;
  logic rst_n;
  wire [3:0] update_loc;
  wire       submit;
  wire       reset;

  int n_checks = 0;
  int n_fail   = 0;

  script_player_if #(.SEL_W(2)) bus ();

  script_player dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .update_loc (update_loc),
    .submit     (submit),
    .reset      (reset)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expects a submit strobe now carrying exp_loc, and that it drops after one cycle.
  task automatic expect_issue(input string tag, input logic [3:0] exp_loc);
    check_eq({tag, "_submit"}, 32'(submit), 32'd1);
    check_eq({tag, "_loc"}, 32'(update_loc), 32'(exp_loc));
    cyc();
    check_eq({tag, "_submit_off"}, 32'(submit), 32'd0);
  endtask

  task automatic give_turn();
    bus.turn = 1'b1;
    cyc();
    bus.turn = 1'b0;
    cyc();
  endtask

  task automatic respond(input logic ack, input logic nak);
    bus.move_ack = ack;
    bus.move_nak = nak;
    cyc();
    bus.move_ack = 1'b0;
    bus.move_nak = 1'b0;
  endtask

  logic [3:0] g0_moves [5] = '{4'd4, 4'd3, 4'd6, 4'd8, 4'd1};

  initial begin
    rst_n        = 1'b0;
    bus.turn     = 1'b0;
    bus.game_sel = 2'd0;
    bus.new_game = 1'b0;
    bus.move_ack = 1'b0;
    bus.move_nak = 1'b0;
    cyc();
    cyc();

    // Reset state
    check_eq("rst_submit", 32'(submit), 32'd0);
    check_eq("rst_reset", 32'(reset), 32'd0);
    check_eq("rst_loc", 32'(update_loc), 32'd0);
    check_eq("rst_mc", 32'(bus.move_count), 32'd0);
    check_eq("rst_done", 32'(bus.script_done), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);

    // Game 0 replayed over alternating turns
    rst_n = 1'b1;
    cyc();
    check_eq("g0_busy", 32'(bus.busy), 32'd1);
    expect_issue("g0_m0", g0_moves[0]);
    respond(1'b1, 1'b0);
    check_eq("g0_mc0", 32'(bus.move_count), 32'd1);
    for (int i = 1; i < 5; i++) begin
      give_turn();
      expect_issue($sformatf("g0_m%0d", i), g0_moves[i]);
      respond(1'b1, 1'b0);
      check_eq($sformatf("g0_mc%0d", i), 32'(bus.move_count), 32'(i + 1));
    end
    give_turn();
    check_eq("g0_done", 32'(bus.script_done), 32'd1);
    check_eq("g0_done_nosub", 32'(submit), 32'd0);
    check_eq("g0_done_busy", 32'(bus.busy), 32'd0);
    cyc();
    check_eq("g0_done_hold", 32'(submit), 32'd0);

    // Skip on reject, game 2
    rst_n        = 1'b0;
    bus.game_sel = 2'd2;
    cyc();
    check_eq("g2_rst_done", 32'(bus.script_done), 32'd0);
    rst_n = 1'b1;
    cyc();
    expect_issue("g2_m0", 4'd2);
    respond(1'b0, 1'b1);
    expect_issue("g2_skip", 4'd0);
    check_eq("g2_skip_mc", 32'(bus.move_count), 32'd0);
    respond(1'b1, 1'b0);
    check_eq("g2_ack_mc", 32'(bus.move_count), 32'd1);

    // Response timeout, game 1
    rst_n        = 1'b0;
    bus.game_sel = 2'd1;
    cyc();
    rst_n = 1'b1;
    cyc();
    expect_issue("g1_m0", 4'd4);
    repeat (15) cyc();
    check_eq("g1_to_early", 32'(submit), 32'd0);
    check_eq("g1_to_busy", 32'(bus.busy), 32'd1);
    cyc();
    expect_issue("g1_to_next", 4'd3);
    check_eq("g1_to_mc", 32'(bus.move_count), 32'd0);
    respond(1'b1, 1'b1);
    check_eq("g1_acknak_mc", 32'(bus.move_count), 32'd1);
    check_eq("g1_acknak_nosub", 32'(submit), 32'd0);

    // Turn loss while waiting for the board
    give_turn();
    expect_issue("g1_m2", 4'd1);
    bus.turn = 1'b1;
    #1;
    check_eq("tl_loc_z", 32'(update_loc === 4'bzzzz), 32'd1);
    check_eq("tl_submit_z", 32'(submit === 1'bz), 32'd1);
    check_eq("tl_reset_z", 32'(reset === 1'bz), 32'd1);
    cyc();
    check_eq("tl_busy", 32'(bus.busy), 32'd0);
    bus.turn = 1'b0;
    cyc();
    expect_issue("tl_retry", 4'd1);
    respond(1'b1, 1'b0);
    check_eq("tl_mc", 32'(bus.move_count), 32'd2);

    // New game mid-game with a second request absorbed
    bus.game_sel = 2'd3;
    bus.new_game = 1'b1;
    cyc();
    bus.new_game = 1'b0;
    check_eq("ng_pending", 32'(reset), 32'd0);
    cyc();
    check_eq("ng_reset1", 32'(reset), 32'd1);
    check_eq("ng_mc", 32'(bus.move_count), 32'd0);
    check_eq("ng_busy", 32'(bus.busy), 32'd1);
    check_eq("ng_nosub", 32'(submit), 32'd0);
    bus.new_game = 1'b1;
    cyc();
    bus.new_game = 1'b0;
    check_eq("ng_reset2", 32'(reset), 32'd1);
    cyc();
    check_eq("ng_reset_off", 32'(reset), 32'd0);
    check_eq("ng_idle", 32'(bus.busy), 32'd0);
    cyc();
    check_eq("ng_reset_stays", 32'(reset), 32'd0);
    expect_issue("ng_first", 4'd8);
    respond(1'b1, 1'b0);
    check_eq("ng_ack_mc", 32'(bus.move_count), 32'd1);
    check_eq("ng_no_restart", 32'(reset), 32'd0);

    // Reset while waiting for a response
    give_turn();
    expect_issue("g3_m1", 4'd7);
    rst_n = 1'b0;
    cyc();
    check_eq("mr_submit", 32'(submit), 32'd0);
    check_eq("mr_mc", 32'(bus.move_count), 32'd0);
    check_eq("mr_done", 32'(bus.script_done), 32'd0);
    check_eq("mr_busy", 32'(bus.busy), 32'd0);
    check_eq("mr_loc", 32'(update_loc), 32'd0);
    rst_n = 1'b1;
    cyc();
    expect_issue("mr_step0", 4'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
